mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the mem_EN / mem_RW / MFC handshake used by the instruction-fetch and operand-access controllers.
- Holds a synchronous word array and models a programmable access latency.
- Performs the read or write, then raises MFC (memory function complete) and holds it until the initiator drops mem_EN.
- Sits between the MAR/MDR datapath and the controller FSMs.

Parameters:
- DW, 16: data word width.
- AW, 8: address width (MAR width).
- DEPTH, 256: number of words; must be a power of two and no greater than 2^AW.
- LATENCY, 3: cycles from request acceptance to MFC rise; legal range 1 to 15.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset; 0 resets immediately, independent of clk.
- mem_EN  input  1  request enable from the controller; held high for the whole transaction.
- mem_RW  input  1  1 = read, 0 = write; sampled on the access edge only.
- addr  input  AW  word address from MAR; sampled on the access edge only.
- data_in  input  DW  write data from MDR; sampled on the access edge only.
- data_out  output  DW  read data to MDR; registered.
- MFC  output  1  memory function complete; registered.
- busy  output  1  high while a request is counting latency (WAIT state).

Behaviour:
- Reset (rst=0): state=IDLE, cnt=0, MFC=0, busy=0, data_out=0. Array contents are not cleared.
- A reset during WAIT aborts the transaction; no write occurs.
- States and transitions, evaluated on each rising clk edge:
  - IDLE: if mem_EN=1, go to WAIT and load cnt=LATENCY-1. Otherwise stay in IDLE.
  - WAIT (busy=1):
    - If mem_EN=0, abort to IDLE. No access, MFC stays 0.
    - Else if cnt=0, perform the access on this edge, set MFC<=1, go to DONE.
    - Else cnt<=cnt-1.
  - DONE (MFC=1, data_out frozen):
    - If mem_EN=0, set MFC<=0 and go to IDLE.
    - Otherwise stay in DONE. A held mem_EN never re-triggers an access.
- Access edge:
  - Read (mem_RW=1): data_out<=mem[addr].
  - Write (mem_RW=0): mem[addr]<=data_in; data_out unchanged.
- Latency: if mem_EN is first seen high at edge k, MFC is first high after edge k+LATENCY. With LATENCY=1, MFC rises one edge after acceptance.
- mem_RW, addr and data_in are don't-care before the access edge. The initiator may change mem_RW during WAIT; only the value at the access edge counts.
- Back-to-back requests need at least one edge with mem_EN=0 (DONE→IDLE). IDLE then accepts a new request on the next edge that sees mem_EN=1.
- data_out holds the last read value until the next read completes. Writes and aborts never disturb it.
- Address decode: index = addr modulo DEPTH (low log2(DEPTH) bits).
- No combinational path from any input to MFC, busy or data_out.

Optional Feature:
- Macro MEM_RESPONDER_BOUNDS_EN.
- Defined:
  - Adds output port mem_ERR (1 bit, reset 0).
  - If addr >= DEPTH at the access edge: the access is suppressed (no write, data_out<=0), MFC still rises normally, and mem_ERR<=1.
  - mem_ERR clears together with MFC on DONE→IDLE.
- Undefined: no mem_ERR port; out-of-range addresses wrap modulo DEPTH.

Test Plan:
- Reset check: hold rst=0 with random inputs → MFC=0, busy=0, data_out=0; release rst → MFC stays 0 while mem_EN=0.
- Write then read, LATENCY=3:
  - Write 16'hBEEF to addr 8'h12 → MFC rises exactly 3 edges after mem_EN is seen; drop mem_EN → MFC=0 next edge.
  - Read addr 8'h12 → data_out=16'hBEEF when MFC rises.
- Fetch-style sequence: mem_EN=1 with mem_RW=0 for one cycle, then mem_RW=1 → treated as a read; mem[addr] unchanged; data_out=stored word.
- Abort: mem_EN drops at cnt=1 during a write of 16'h0000 to an addr holding 16'h1234 → MFC never rises, mem stays 16'h1234, busy=0 next edge.
- Hold and reset: keep mem_EN high 10 cycles past MFC → exactly one access, MFC held high. Separately, assert rst mid-WAIT → IDLE immediately, no write.
- With MEM_RESPONDER_BOUNDS_EN and DEPTH=128: read addr 8'hC0 → MFC=1, mem_ERR=1, data_out=0. Write to 8'hC0 → mem[8'h40] unchanged.

Source files
------------

// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bundle between a controller and mem_responder.
// Latency: none, plain wires; all timing lives in the responder.
// Backpressure: MFC held by the responder until the controller drops mem_EN.
// Optional: MEM_RESPONDER_BOUNDS_EN adds the mem_ERR response bit.
interface mem_responder_if #(
  parameter int DW = 16,
  parameter int AW = 8
);
  logic          mem_EN;
  logic          mem_RW;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          MFC;
  logic          busy;
`ifdef MEM_RESPONDER_BOUNDS_EN
  logic          mem_ERR;
`endif

  // Controller side: issues requests, consumes completion and read data.
  modport master (
    output mem_EN,
    output mem_RW,
    output addr,
    output data_in,
    input  data_out,
    input  MFC,
`ifdef MEM_RESPONDER_BOUNDS_EN
    input  mem_ERR,
`endif
    input  busy
  );

  // Memory side: samples requests, drives completion and read data.
  modport slave (
    input  mem_EN,
    input  mem_RW,
    input  addr,
    input  data_in,
    output data_out,
    output MFC,
`ifdef MEM_RESPONDER_BOUNDS_EN
    output mem_ERR,
`endif
    output busy
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word memory answering the mem_EN/mem_RW/MFC handshake.
// Latency: MFC rises LATENCY edges after the edge that first sees mem_EN high.
// Backpressure: MFC held until mem_EN drops; one mem_EN-low edge between requests.
// Optional: MEM_RESPONDER_BOUNDS_EN adds mem_ERR and suppresses accesses with addr >= DEPTH.
module mem_responder #(
  parameter int DW      = 16,
  parameter int AW      = 8,
  parameter int DEPTH   = 256,  // power of two, 2 .. 2**AW
  parameter int LATENCY = 3     // 1 .. 15
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave bus
);

  localparam int         IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic          mfc_q;
  logic [DW-1:0] dout_q;
  logic [DW-1:0] mem [DEPTH];

  logic [IW-1:0] idx;
  logic          access;
  logic          in_range;
  logic          wr_en;
  logic          rd_en;

  // Low address bits select the word; upper bits wrap unless bounds checking is on.
  assign idx    = bus.addr[IW-1:0];

  // The access edge is the WAIT edge where the countdown has expired and the
  // request is still alive; mem_RW/addr/data_in matter only here.
  assign access = (state == ST_WAIT) && bus.mem_EN && (cnt == 4'd0);

`ifdef MEM_RESPONDER_BOUNDS_EN
  logic err_q;

  assign in_range    = ({1'b0, bus.addr} < (AW + 1)'(DEPTH));
  assign bus.mem_ERR = err_q;
`else
  assign in_range    = 1'b1;
`endif

  assign wr_en = access && !bus.mem_RW && in_range;
  assign rd_en = access &&  bus.mem_RW;

  // Word array: write port only, never reset so contents survive rst.
  // A reset forces state to IDLE asynchronously, so access (and wr_en) is
  // already low on any edge seen while rst is asserted.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[idx] <= bus.data_in;
    end
  end

  // Handshake FSM with latency counter, completion flag and read-data register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      cnt    <= 4'd0;
      mfc_q  <= 1'b0;
      dout_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.mem_EN) begin
            state <= ST_WAIT;
            cnt   <= CNT_LOAD;
          end
        end
        ST_WAIT: begin
          if (!bus.mem_EN) begin
            // Initiator gave up: no access, MFC never rises.
            state <= ST_IDLE;
          end else if (cnt == 4'd0) begin
            state <= ST_DONE;
            mfc_q <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_DONE: begin
          // Held mem_EN keeps us here without a second access.
          if (!bus.mem_EN) begin
            state <= ST_IDLE;
            mfc_q <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          mfc_q <= 1'b0;
        end
      endcase

      // data_out only moves on a read (or, with bounds checking, on a rejected
      // access); writes and aborts leave the last read value in place.
      if (access && !in_range) begin
        dout_q <= '0;
      end else if (rd_en) begin
        dout_q <= mem[idx];
      end
    end
  end

`ifdef MEM_RESPONDER_BOUNDS_EN
  // Error flag rises with MFC on a rejected access and clears with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (access) begin
      err_q <= !in_range;
    end else if (state == ST_DONE && !bus.mem_EN) begin
      err_q <= 1'b0;
    end
  end
`endif

  assign bus.data_out = dout_q;
  assign bus.MFC      = mfc_q;
  assign bus.busy     = (state == ST_WAIT);

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed bench with a read-data scoreboard for mem_responder.
// Latency: checks MFC timing against LATENCY on every transaction.
// Backpressure: exercises hold, abort and reset-in-flight cases.
module tb_mem_responder;

  localparam int DW      = 16;
  localparam int AW      = 8;
  localparam int DEPTH   = 128;
  localparam int LATENCY = 3;

  logic clk;
  logic rst;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] last_rd;

  mem_responder_if #(.DW(DW), .AW(AW)) bus ();

  mem_responder #(
    .DW     (DW),
    .AW     (AW),
    .DEPTH  (DEPTH),
    .LATENCY(LATENCY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction. mem_RW starts at rw_first and switches to rw_final
  // after the acceptance edge; hold = extra cycles mem_EN stays high past MFC.
  task automatic txn(input logic rw_first, input logic rw_final,
                     input logic [AW-1:0] a, input logic [DW-1:0] d, input int hold);
    int            n;
    int            hi;
    logic          exp_err;
    logic [DW-1:0] exp_d;
    exp_err = 1'b0;
`ifdef MEM_RESPONDER_BOUNDS_EN
    exp_err = (a >= AW'(DEPTH));
`endif
    if (exp_err)       last_rd = '0;
    else if (rw_final) last_rd = model[a[6:0]];
    else               model[a[6:0]] = d;
    exp_q.push_back(last_rd);

    bus.mem_EN  = 1'b1;
    bus.mem_RW  = rw_first;
    bus.addr    = a;
    bus.data_in = d;
    tick();
    bus.mem_RW = rw_final;
    check("busy_after_accept", {31'd0, bus.busy}, 32'd1);
    n = 1;
    while (!bus.MFC && n < 40) begin
      tick();
      n++;
    end
    check("mfc_latency_edges", n, LATENCY + 1);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      exp_d = exp_q.pop_front();
      check("data_out_at_mfc", {16'd0, bus.data_out}, {16'd0, exp_d});
    end
`ifdef MEM_RESPONDER_BOUNDS_EN
    check("mem_err_at_mfc", {31'd0, bus.mem_ERR}, {31'd0, exp_err});
`endif
    if (hold > 0) begin
      hi = 0;
      for (int i = 0; i < hold; i++) begin
        bus.data_in = ~d;
        bus.mem_RW  = ~rw_final;
        tick();
        if (bus.MFC === 1'b1 && bus.data_out === last_rd) hi++;
      end
      check("hold_mfc_cycles", hi, hold);
    end
    bus.mem_EN  = 1'b0;
    bus.addr    = AW'($urandom);
    bus.data_in = DW'($urandom);
    tick();
    check("mfc_drop", {31'd0, bus.MFC}, 32'd0);
    check("busy_idle", {31'd0, bus.busy}, 32'd0);
`ifdef MEM_RESPONDER_BOUNDS_EN
    check("mem_err_clear", {31'd0, bus.mem_ERR}, 32'd0);
`endif
  endtask

  initial begin
    int hi;
    rst         = 1'b0;
    bus.mem_EN  = 1'b0;
    bus.mem_RW  = 1'b0;
    bus.addr    = '0;
    bus.data_in = '0;
    last_rd     = '0;

    // Reset with random input activity.
    for (int i = 0; i < 5; i++) begin
      bus.mem_EN  = 1'($urandom);
      bus.mem_RW  = 1'($urandom);
      bus.addr    = AW'($urandom);
      bus.data_in = DW'($urandom);
      tick();
    end
    check("rst_mfc", {31'd0, bus.MFC}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_data_out", {16'd0, bus.data_out}, 32'd0);
    bus.mem_EN = 1'b0;
    rst = 1'b1;
    hi = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.MFC !== 1'b0) hi++;
    end
    check("post_rst_mfc_low", hi, 0);

    // Write then read back.
    txn(1'b0, 1'b0, 8'h12, 16'hBEEF, 0);
    txn(1'b1, 1'b1, 8'h12, 16'h0000, 0);

    // A few more words, including the array edges.
    for (int i = 0; i < 4; i++) txn(1'b0, 1'b0, 8'(i * 37), 16'(16'h1111 * (i + 1)), 0);
    txn(1'b0, 1'b0, 8'h00, 16'hA5A5, 0);
    txn(1'b0, 1'b0, 8'h7F, 16'h5A5A, 0);
    for (int i = 0; i < 4; i++) txn(1'b1, 1'b1, 8'(i * 37), 16'h0, 0);
    txn(1'b1, 1'b1, 8'h7F, 16'h0, 0);
    txn(1'b1, 1'b1, 8'h00, 16'h0, 0);

    // Fetch style: starts as a write, becomes a read before the access edge.
    txn(1'b0, 1'b1, 8'h12, 16'hDEAD, 0);
    txn(1'b1, 1'b1, 8'h12, 16'h0, 0);

    // Abort with cnt=1.
    txn(1'b0, 1'b0, 8'h30, 16'h1234, 0);
    bus.mem_EN  = 1'b1;
    bus.mem_RW  = 1'b0;
    bus.addr    = 8'h30;
    bus.data_in = 16'h0000;
    tick();
    tick();
    bus.mem_EN = 1'b0;
    tick();
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_data_out", {16'd0, bus.data_out}, {16'd0, last_rd});
    hi = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.MFC !== 1'b0) hi++;
      tick();
    end
    check("abort_mfc_never", hi, 0);
    txn(1'b1, 1'b1, 8'h30, 16'h0, 0);

    // Hold mem_EN 10 cycles past MFC; changed data must not be written.
    txn(1'b0, 1'b0, 8'h21, 16'hC0DE, 10);
    txn(1'b1, 1'b1, 8'h21, 16'h0, 10);

    // Reset in the middle of WAIT.
    txn(1'b0, 1'b0, 8'h31, 16'hAAAA, 0);
    txn(1'b1, 1'b1, 8'h30, 16'h0, 0);
    bus.mem_EN  = 1'b1;
    bus.mem_RW  = 1'b0;
    bus.addr    = 8'h31;
    bus.data_in = 16'h0BAD;
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    check("midwait_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("midwait_rst_mfc", {31'd0, bus.MFC}, 32'd0);
    check("midwait_rst_data_out", {16'd0, bus.data_out}, 32'd0);
    last_rd = '0;
    tick();
    tick();
    bus.mem_EN = 1'b0;
    rst = 1'b1;
    tick();
    check("post_midwait_mfc", {31'd0, bus.MFC}, 32'd0);
    txn(1'b1, 1'b1, 8'h31, 16'h0, 0);

    // Addresses above DEPTH: wrap by default, rejected with bounds checking.
    txn(1'b0, 1'b0, 8'h40, 16'h7777, 0);
    txn(1'b0, 1'b0, 8'hC0, 16'h9999, 0);
    txn(1'b1, 1'b1, 8'hC0, 16'h0, 0);
    txn(1'b1, 1'b1, 8'h40, 16'h0, 0);

    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
